cdb_writeback: RTL and testbench

//  Result-writeback stage between functional units and the ROB/commit stage. Accepts completed

---
 rtl/tomasulo_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/cdb_writeback.sv | 92 +++++++++
 tb/tb_cdb_writeback.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared out-of-order core types: ROB tag/value widths and the common data bus record.
// Used by the writeback stage, the ROB/commit logic and the reservation stations.
package tomasulo_pkg;

    localparam int TAG_W     = 2;
    localparam int DATA_W    = 32;
    localparam int ROB_DEPTH = 1 << TAG_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr (wrapping) wins.
// Shared by the CDB writeback stage and the issue stage.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_gnt_idx,
    output logic             o_any
);

    logic [PTR_W-1:0] w_pos;

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_pos     = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = PTR_W'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_gnt_idx    = w_pos;
            end
        end
    end

endmodule

// File: rtl/cdb_writeback.sv
// Result writeback: one holding buffer per functional unit, round-robin pick of one per cycle,
// and a registered common data bus that writes the ROB and wakes reservation stations.
module cdb_writeback
    import tomasulo_pkg::*;
#(
    parameter int N_FU   = 2,
    parameter int TAG_W  = tomasulo_pkg::TAG_W,
    parameter int DATA_W = tomasulo_pkg::DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [N_FU-1:0]        fu_valid,
    output logic [N_FU-1:0]        fu_ready,
    input  logic [N_FU*TAG_W-1:0]  fu_tag,
    input  logic [N_FU*DATA_W-1:0] fu_value,
    output logic                   cdb_valid,
    output logic [TAG_W-1:0]       cdb_tag,
    output logic [DATA_W-1:0]      cdb_value,
    output logic [N_FU-1:0]        cdb_src
);

    localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [N_FU-1:0]   r_full;
    logic [TAG_W-1:0]  r_tag   [N_FU];
    logic [DATA_W-1:0] r_value [N_FU];
    logic [PTR_W-1:0]  r_rr_ptr;
    cdb_t              r_cdb;
    logic [N_FU-1:0]   r_cdb_src;

    logic [N_FU-1:0]   w_gnt;
    logic [N_FU-1:0]   w_accept;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic              w_any;
    logic              w_open;

    // Arbitration sees only registered occupancy, so fu_valid never reaches fu_ready combinationally.
    rr_arbiter #(
        .N (N_FU)
    ) u_arb (
        .i_req     (r_full),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign w_open   = !rst && !flush;
    assign fu_ready = {N_FU{w_open}} & (~r_full | w_gnt);
    assign w_accept = fu_valid & fu_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= '0;
            r_rr_ptr  <= '0;
            r_cdb     <= '0;
            r_cdb_src <= '0;
        end else if (flush) begin
            r_full      <= '0;
            r_cdb.valid <= 1'b0;
        end else begin
            r_full <= (r_full & ~w_gnt) | w_accept;
            if (w_any) begin
                r_cdb.valid <= 1'b1;
                r_cdb.tag   <= r_tag[w_gnt_idx];
                r_cdb.value <= r_value[w_gnt_idx];
                r_cdb_src   <= w_gnt;
                r_rr_ptr    <= (w_gnt_idx == PTR_W'(N_FU - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
            end else begin
                r_cdb.valid <= 1'b0;
            end
        end
    end

    // NOTE: payload storage is not reset; r_full alone says whether an entry holds a result.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (w_accept[i]) begin
                r_tag[i]   <= fu_tag[i*TAG_W +: TAG_W];
                r_value[i] <= fu_value[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_valid = r_cdb.valid;
    assign cdb_tag   = r_cdb.tag;
    assign cdb_value = r_cdb.value;
    assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed scenarios plus random traffic, all checked every cycle
// against a queue-based model of per-unit buffering and round-robin broadcast.
module tb_cdb_writeback;

    localparam int N  = 2;
    localparam int TW = 2;
    localparam int DW = 32;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] value;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [N-1:0]    fu_valid;
    logic [N-1:0]    fu_ready;
    logic [N*TW-1:0] fu_tag;
    logic [N*DW-1:0] fu_value;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_value;
    logic [N-1:0]    cdb_src;

    int n_vec = 0;
    int n_err = 0;

    // Model state: what each unit holds, whose turn it is, and what the bus shows.
    res_t          q [N][$];
    int            m_ptr;
    logic          m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_value;
    logic [N-1:0]  m_src;
    logic [N-1:0]  last_rdy;

    always #5 clk = ~clk;

    cdb_writeback #(
        .N_FU   (N),
        .TAG_W  (TW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_value = '0;
        m_src   = '0;
    endtask

    // One clock: drive inputs, compare DUT to model before the edge, then advance the model.
    task automatic step(input logic r, input logic f, input logic [N-1:0] v,
                        input logic [TW-1:0] t0, input logic [DW-1:0] d0,
                        input logic [TW-1:0] t1, input logic [DW-1:0] d1);
        int           g;
        logic [N-1:0] exp_rdy;
        res_t         in_res [N];
        @(negedge clk);
        rst      = r;
        flush    = f;
        fu_valid = v;
        fu_tag   = {t1, t0};
        fu_value = {d1, d0};
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && q[idx].size() > 0) g = idx;
        end
        for (int i = 0; i < N; i++)
            exp_rdy[i] = !r && !f && (q[i].size() == 0 || i == g);
        last_rdy = fu_ready;
        check("fu_ready", 64'(fu_ready), 64'(exp_rdy));
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        check("cdb_value", 64'(cdb_value), 64'(m_value));
        check("cdb_src", 64'(cdb_src), 64'(m_src));
        @(posedge clk);
        in_res[0].tag = t0; in_res[0].value = d0;
        in_res[1].tag = t1; in_res[1].value = d1;
        if (r) begin
            model_reset();
        end else if (f) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_valid = 1'b0;
        end else begin
            if (g >= 0) begin
                res_t head;
                head    = q[g].pop_front();
                m_valid = 1'b1;
                m_tag   = head.tag;
                m_value = head.value;
                m_src   = N'(1) << g;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < N; i++)
                if (v[i] && exp_rdy[i]) q[i].push_back(in_res[i]);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    endtask

    // Hand-computed expectations, sampled just after the edge that produced them.
    task automatic expect_cdb(input string name, input logic v, input logic [TW-1:0] t,
                              input logic [DW-1:0] d, input logic [N-1:0] s);
        #1;
        check({name, "_valid"}, 64'(cdb_valid), 64'(v));
        check({name, "_tag"}, 64'(cdb_tag), 64'(t));
        check({name, "_value"}, 64'(cdb_value), 64'(d));
        check({name, "_src"}, 64'(cdb_src), 64'(s));
    endtask

    task automatic expect_idle(input string name);
        #1;
        check({name, "_valid"}, 64'(cdb_valid), 64'(0));
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;
        model_reset();
        @(posedge clk);

        // Reset held three cycles with both units offering results.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'b11, 2'd1, 32'hDEAD, 2'd2, 32'hBEEF);
            check("rst_ready", 64'(last_rdy), 64'(0));
        end
        expect_cdb("rst", 1'b0, '0, '0, '0);
        idle();
        expect_idle("post_rst");

        // Single result from the adder: visible one edge after acceptance.
        step(1'b0, 1'b0, 2'b01, 2'd1, 32'h0000_00AA, 2'd0, 32'h0);
        expect_idle("single_k");
        idle();
        expect_cdb("single_k1", 1'b1, 2'd1, 32'h0000_00AA, 2'b01);
        idle();
        expect_idle("single_k2");

        // Contention from rr_ptr=0: adder first, multiplier next.
        do_reset();
        step(1'b0, 1'b0, 2'b11, 2'd0, 32'h11, 2'd3, 32'h33);
        idle();
        expect_cdb("cont_u0", 1'b1, 2'd0, 32'h11, 2'b01);
        idle();
        expect_cdb("cont_u1", 1'b1, 2'd3, 32'h33, 2'b10);
        check("cont_ptr_model", 64'(m_ptr), 64'(0));

        // Streaming: both units every cycle for eight cycles.
        do_reset();
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 2'b11, TW'(i), 32'h1000 + i, TW'(i + 1), 32'h2000 + i);
        for (int i = 0; i < 4; i++) idle();

        // Flush in the grant cycle drops the buffered multiplier result.
        do_reset();
        step(1'b0, 1'b0, 2'b10, 2'd0, 32'h0, 2'd1, 32'h55);
        step(1'b0, 1'b1, 2'b11, 2'd2, 32'h66, 2'd2, 32'h77);
        check("flush_ready", 64'(last_rdy), 64'(0));
        expect_idle("flush_k");
        idle();
        expect_idle("flush_k1");

        // Refill-on-grant keeps the adder streaming.
        do_reset();
        step(1'b0, 1'b0, 2'b01, 2'd2, 32'h100, 2'd0, 32'h0);
        step(1'b0, 1'b0, 2'b01, 2'd3, 32'h200, 2'd0, 32'h0);
        check("refill_ready", 64'(last_rdy[0]), 64'(1));
        expect_cdb("refill_a", 1'b1, 2'd2, 32'h100, 2'b01);
        idle();
        expect_cdb("refill_b", 1'b1, 2'd3, 32'h200, 2'b01);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, N'($urandom),
                 TW'($urandom), $urandom, TW'($urandom), $urandom);
        end
        for (int i = 0; i < 4; i++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
